csr_trap: RTL

- Machine-mode trap CSR file: the state-holding counterpart to the jump/trap-target unit.
- Consumes trap_taken, trap_src and trap_return from that unit, and captures mepc, mcause, mtval and the mstatus interrupt-enable stack.
- Supplies mtvec_rdata, mepc_rdata and the gated external_int request back to it.
- Also services Zicsr accesses from execute and runs the mcycle/minstret counters.

---
 rtl/csr_trap.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/csr_trap.sv
// Machine-mode trap CSR file: holds mstatus/mie/mtvec/mscratch/mepc/mcause/
// mtval/mip plus the mcycle/minstret counters, captures trap state from the
// jump unit, services Zicsr accesses from execute, and feeds mtvec/mepc and
// the gated external interrupt request back to the jump unit.
module csr_trap #(
    parameter logic [31:0] MTVEC_RESET = 32'h00000000,
    parameter logic [31:0] HART_ID     = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ext_irq,
    input  logic        trap_taken,
    input  logic        trap_return,
    input  logic [4:0]  trap_src,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_tval,
    input  logic        instret,
    input  logic [1:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    output logic [31:0] mtvec_rdata,
    output logic [31:0] mepc_rdata,
    output logic        external_int
);

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MTVAL     = 12'h343;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_MHARTID   = 12'hF14;

    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;

    localparam logic [4:0] SRC_NONE = 5'b11111;

    // Architectural state
    logic        mstatus_mie_q,  mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic        meie_q,         meie_d;
    logic        irq_sync1_q;
    logic        irq_sync2_q;
    logic [31:0] mtvec_q,        mtvec_d;
    logic [31:0] mscratch_q,     mscratch_d;
    logic [31:0] mepc_q,         mepc_d;
    logic [31:0] mcause_q,       mcause_d;
    logic [31:0] mtval_q,        mtval_d;
    logic [63:0] mcycle_q,       mcycle_d;
    logic [63:0] minstret_q,     minstret_d;

    // Access decode
    logic        entry;
    logic        ret;
    logic [31:0] old_val;
    logic [31:0] wval;
    logic        mapped;
    logic        read_only;
    logic        eff_write;
    logic        illegal;
    logic        do_write;
    logic [31:0] mstatus_rd;

    // Applies the Zicsr operation to the current CSR value.
    function automatic logic [31:0] csr_wval(input logic [1:0]  op,
                                             input logic [31:0] old,
                                             input logic [31:0] wd);
        logic [31:0] res;
        case (op)
            OP_WRITE: res = wd;
            OP_SET:   res = old | wd;
            default:  res = old & ~wd;
        endcase
        return res;
    endfunction

    assign entry = trap_taken && (trap_src != SRC_NONE);
    assign ret   = trap_return && !entry;

    // MPP is hardwired to machine mode; only MIE/MPIE are storage.
    assign mstatus_rd = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};

    // Read mux: selects the pre-update value and classifies the address.
    always_comb begin
        old_val   = '0;
        mapped    = 1'b1;
        read_only = 1'b0;
        case (csr_addr)
            A_MSTATUS:   old_val = mstatus_rd;
            A_MIE:       old_val = {20'b0, meie_q, 11'b0};
            A_MTVEC:     old_val = mtvec_q;
            A_MSCRATCH:  old_val = mscratch_q;
            A_MEPC:      old_val = mepc_q;
            A_MCAUSE:    old_val = mcause_q;
            A_MTVAL:     old_val = mtval_q;
            A_MIP: begin
                old_val   = {20'b0, irq_sync2_q, 11'b0};
                read_only = 1'b1;
            end
            A_MCYCLE:    old_val = mcycle_q[31:0];
            A_MCYCLEH:   old_val = mcycle_q[63:32];
            A_MINSTRET:  old_val = minstret_q[31:0];
            A_MINSTRETH: old_val = minstret_q[63:32];
            A_MHARTID: begin
                old_val   = HART_ID;
                read_only = 1'b1;
            end
            default:     mapped = 1'b0;
        endcase
    end

    // Set/clear with a zero operand is a pure read and never counts as a write.
    always_comb begin
        eff_write   = (csr_op == OP_WRITE) || ((csr_op != OP_NONE) && (csr_wdata != 32'h0));
        illegal     = (csr_op != OP_NONE) && (!mapped || (eff_write && read_only));
        do_write    = eff_write && !illegal && !entry && !ret;
        wval        = csr_wval(csr_op, old_val, csr_wdata);
        csr_rdata   = ((csr_op != OP_NONE) && mapped) ? old_val : 32'h0;
        csr_illegal = illegal;
    end

    // Next-state: trap entry beats return, which beats any CSR write.
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        meie_d         = meie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;
        mcycle_d       = mcycle_q + 64'd1;
        minstret_d     = minstret_q + {63'b0, instret};

        if (entry) begin
            mepc_d         = trap_pc & 32'hFFFF_FFFC;
            mcause_d       = {trap_src[4], 27'b0, trap_src[3:0]};
            mtval_d        = trap_src[4] ? 32'h0 : trap_tval;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (ret) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else if (do_write) begin
            case (csr_addr)
                A_MSTATUS: begin
                    mstatus_mie_d  = wval[3];
                    mstatus_mpie_d = wval[7];
                end
                A_MIE:       meie_d     = wval[11];
                A_MTVEC:     mtvec_d    = wval & 32'hFFFF_FFFC;
                A_MSCRATCH:  mscratch_d = wval;
                A_MEPC:      mepc_d     = wval & 32'hFFFF_FFFC;
                A_MCAUSE:    mcause_d   = wval;
                A_MTVAL:     mtval_d    = wval;
                A_MCYCLE:    mcycle_d   = {mcycle_q[63:32], wval};
                A_MCYCLEH:   mcycle_d   = {wval, mcycle_q[31:0]};
                A_MINSTRET:  minstret_d = {minstret_q[63:32], wval};
                A_MINSTRETH: minstret_d = {wval, minstret_q[31:0]};
                default: ;
            endcase
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            meie_q         <= 1'b0;
            irq_sync1_q    <= 1'b0;
            irq_sync2_q    <= 1'b0;
            mtvec_q        <= {MTVEC_RESET[31:2], 2'b00};
            mscratch_q     <= 32'h0;
            mepc_q         <= 32'h0;
            mcause_q       <= 32'h0;
            mtval_q        <= 32'h0;
            mcycle_q       <= 64'h0;
            minstret_q     <= 64'h0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            meie_q         <= meie_d;
            irq_sync1_q    <= ext_irq;
            irq_sync2_q    <= irq_sync1_q;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
            mcycle_q       <= mcycle_d;
            minstret_q     <= minstret_d;
        end
    end

    // Outputs to the jump unit are taken straight from flops.
    assign mtvec_rdata  = mtvec_q;
    assign mepc_rdata   = mepc_q;
    assign external_int = irq_sync2_q & meie_q & mstatus_mie_q;

endmodule
